// File: rtl/ex_mem_skid_register_pkg.sv
// Shared types and constants for the EX/MEM skid register.
// Optional perf counters: EX_MEM_PERF_COUNTERS_EN.
package ex_mem_skid_register_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int CTRL_W_DEF = 4;

  localparam int CTRL_MEM_READ   = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_REG_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] store_data;
    logic [REG_W_DEF-1:0]  reg_dst;
    logic [CTRL_W_DEF-1:0] ctrl;
  } ex_mem_bundle_t;

  // Occupancy encoded as {skid_valid, head_valid}
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b11
  } occ_e;

endpackage

// File: rtl/ex_mem_skid_register_skid_entry.sv
// One valid+payload register with load and clear.
// Clear wins over load; reset zeroes the payload.
module ex_mem_skid_register_skid_entry #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next-state: clear drops the entry, load captures new payload
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_skid_register.sv
// EX/MEM boundary with a two-entry skid buffer and forwarding tap.
// Optional perf counters: EX_MEM_PERF_COUNTERS_EN.
module ex_mem_skid_register
  import ex_mem_skid_register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Flush,
  input  logic              i_In_Valid,
  output logic              o_In_Ready,
  input  logic [DATA_W-1:0] i_ALU_Result,
  input  logic [DATA_W-1:0] i_Store_Data,
  input  logic [REG_W-1:0]  i_Reg_Dst,
  input  logic [CTRL_W-1:0] i_Ctrl,
  output logic              o_Out_Valid,
  input  logic              i_Out_Ready,
  output logic [DATA_W-1:0] o_ALU_Result,
  output logic [DATA_W-1:0] o_Store_Data,
  output logic [REG_W-1:0]  o_Reg_Dst,
  output logic [CTRL_W-1:0] o_Ctrl,
`ifdef EX_MEM_PERF_COUNTERS_EN
  output logic [31:0]       o_Stall_Count,
  output logic [31:0]       o_Xfer_Count,
`endif
  output logic              o_Fwd_Valid,
  output logic [REG_W-1:0]  o_Fwd_Reg,
  output logic [DATA_W-1:0] o_Fwd_Data
);

  localparam int PW = 2*DATA_W + REG_W + CTRL_W;

  logic          head_v, skid_v;
  logic [PW-1:0] head_q, skid_q, in_pl, head_d;
  logic          head_load, head_clr;
  logic          skid_load, skid_clr;
  logic          head_sel_skid;
  logic          in_fire, out_fire;
  occ_e          occ;

  assign in_pl    = {i_ALU_Result, i_Store_Data, i_Reg_Dst, i_Ctrl};
  assign in_fire  = i_In_Valid & ~skid_v;
  assign out_fire = head_v & i_Out_Ready;
  assign occ      = occ_e'({skid_v, head_v});
  assign head_d   = head_sel_skid ? skid_q : in_pl;

  // Occupancy transitions; flush overrides any load
  always_comb begin
    head_load     = 1'b0;
    head_clr      = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    head_sel_skid = 1'b0;
    case (occ)
      OCC_EMPTY: head_load = in_fire;
      OCC_ONE: begin
        if (in_fire && out_fire) head_load = 1'b1;
        else if (out_fire)       head_clr  = 1'b1;
        else if (in_fire)        skid_load = 1'b1;
      end
      OCC_TWO: begin
        if (out_fire) begin
          head_load     = 1'b1;
          head_sel_skid = 1'b1;
          skid_clr      = 1'b1;
        end
      end
      default: begin
        head_clr = 1'b1;
        skid_clr = 1'b1;
      end
    endcase
    if (i_Flush) begin
      head_load = 1'b0;
      skid_load = 1'b0;
      head_clr  = 1'b1;
      skid_clr  = 1'b1;
    end
  end

  ex_mem_skid_register_skid_entry #(.W(PW)) u_head (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .clr_i   (head_clr),
    .load_i  (head_load),
    .data_i  (head_d),
    .valid_o (head_v),
    .data_o  (head_q)
  );

  ex_mem_skid_register_skid_entry #(.W(PW)) u_skid (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .clr_i   (skid_clr),
    .load_i  (skid_load),
    .data_i  (in_pl),
    .valid_o (skid_v),
    .data_o  (skid_q)
  );

  // Outputs come straight from registered state
  always_comb begin
    o_In_Ready  = ~skid_v;
    o_Out_Valid = head_v;
    {o_ALU_Result, o_Store_Data, o_Reg_Dst, o_Ctrl} = head_q;
    o_Fwd_Reg   = o_Reg_Dst;
    o_Fwd_Data  = o_ALU_Result;
    o_Fwd_Valid = head_v & o_Ctrl[CTRL_REG_WRITE] & (o_Reg_Dst != '0);
  end

`ifdef EX_MEM_PERF_COUNTERS_EN
  logic [31:0] stall_q, stall_d, xfer_q, xfer_d;

  // Saturating counters; flush does not touch them
  always_comb begin
    stall_d = stall_q;
    xfer_d  = xfer_q;
    if (head_v && !i_Out_Ready && stall_q != '1) stall_d = stall_q + 32'd1;
    if (out_fire && xfer_q != '1) xfer_d = xfer_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  assign o_Stall_Count = stall_q;
  assign o_Xfer_Count  = xfer_q;
`endif

endmodule
